// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the system-controller command path: opcodes, operand
// register addresses, parser and TX sequencer state codes.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam logic [3:0] OPERAND_A_ADDR = 4'd0;
    localparam logic [3:0] OPERAND_B_ADDR = 4'd1;

    // Parser states (plain constants so existing state decoders keep working)
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_WR_ADDR  = 4'd1;
    localparam logic [3:0] ST_WR_DATA  = 4'd2;
    localparam logic [3:0] ST_RD_ADDR  = 4'd3;
    localparam logic [3:0] ST_RD_WAIT  = 4'd4;
    localparam logic [3:0] ST_OP_A     = 4'd5;
    localparam logic [3:0] ST_OP_B     = 4'd6;
    localparam logic [3:0] ST_ALU_FUN  = 4'd7;
    localparam logic [3:0] ST_ALU_WAIT = 4'd8;
    localparam logic [3:0] ST_TX_SEND  = 4'd9;

    // TX sequencer states
    localparam logic [1:0] TX_IDLE    = 2'd0;
    localparam logic [1:0] TX_ISSUE   = 2'd1;
    localparam logic [1:0] TX_WAIT_HI = 2'd2;
    localparam logic [1:0] TX_WAIT_LO = 2'd3;

endpackage

// File: rtl/sys_ctrl_tx_seq.sv
// Result byte sequencer: holds a 1- or 2-byte result, hands it to the UART TX
// LSB first using the tx_busy rise/fall handshake, and pulses done at the end.
module sys_ctrl_tx_seq
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    load,
    input  logic [2*DATA_WIDTH-1:0] load_data,
    input  logic                    load_two,
    input  logic                    tx_busy,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    output logic                    done
);

    logic [1:0]              st;
    logic [2*DATA_WIDTH-1:0] buf_q;
    logic                    more_q;

    assign tx_data  = buf_q[DATA_WIDTH-1:0];
    // Issue is gated by the live tx_busy so a pulse never lands on a busy cycle
    assign tx_valid = (st == TX_ISSUE) && !tx_busy;
    assign done     = (st == TX_WAIT_LO) && !tx_busy && !more_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st     <= TX_IDLE;
            buf_q  <= '0;
            more_q <= 1'b0;
        end else begin
            case (st)
                TX_IDLE: begin
                    if (load) begin
                        buf_q  <= load_data;
                        more_q <= load_two;
                        st     <= TX_ISSUE;
                    end
                end
                TX_ISSUE: begin
                    if (!tx_busy) st <= TX_WAIT_HI;
                end
                TX_WAIT_HI: begin
                    if (tx_busy) st <= TX_WAIT_LO;
                end
                TX_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (more_q) begin
                            buf_q  <= buf_q >> DATA_WIDTH;
                            more_q <= 1'b0;
                            st     <= TX_ISSUE;
                        end else begin
                            st <= TX_IDLE;
                        end
                    end
                end
                default: st <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// Command front end: parses RX command frames, drives register file and ALU,
// and returns read/ALU results through the TX sequencer.
module sys_cmd_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    output logic [ADDR_WIDTH-1:0]   rf_addr,
    output logic                    rf_wr_en,
    output logic [DATA_WIDTH-1:0]   rf_wr_data,
    output logic                    rf_rd_en,
    input  logic [DATA_WIDTH-1:0]   rf_rd_data,
    input  logic                    rf_rd_valid,
    output logic                    alu_en,
    output logic [FUN_WIDTH-1:0]    alu_fun,
    input  logic [2*DATA_WIDTH-1:0] alu_out,
    input  logic                    alu_out_valid,
    output logic                    clk_gate_en,
    output logic [DATA_WIDTH-1:0]   tx_data,
    output logic                    tx_valid,
    input  logic                    tx_busy,
    output logic                    cmd_err
);

    logic [3:0]              state;
    logic                    gate_q;
    logic                    tx_load;
    logic [2*DATA_WIDTH-1:0] tx_load_data;
    logic                    tx_load_two;
    logic                    tx_done;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        tx_load      = 1'b0;
        tx_load_data = '0;
        tx_load_two  = 1'b0;
        if (state == ST_RD_WAIT && rf_rd_valid) begin
            tx_load      = 1'b1;
            tx_load_data = {{DATA_WIDTH{1'b0}}, rf_rd_data};
        end else if (state == ST_ALU_WAIT && alu_out_valid) begin
            tx_load      = 1'b1;
            tx_load_data = alu_out;
            tx_load_two  = 1'b1;
        end
    end

    // The gate opens in the very cycle the function byte is accepted
    assign clk_gate_en = gate_q || (state == ST_ALU_FUN && rx_valid);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            rf_addr    <= '0;
            rf_wr_en   <= 1'b0;
            rf_wr_data <= '0;
            rf_rd_en   <= 1'b0;
            alu_en     <= 1'b0;
            alu_fun    <= '0;
            gate_q     <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            rf_wr_en <= 1'b0;
            rf_rd_en <= 1'b0;
            cmd_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == DATA_WIDTH'(CMD_WR))            state <= ST_WR_ADDR;
                        else if (rx_data == DATA_WIDTH'(CMD_RD))       state <= ST_RD_ADDR;
                        else if (rx_data == DATA_WIDTH'(CMD_ALU_OP))   state <= ST_OP_A;
                        else if (rx_data == DATA_WIDTH'(CMD_ALU_NOP))  state <= ST_ALU_FUN;
                        else                                           cmd_err <= 1'b1;
                    end
                end
                ST_WR_ADDR: begin
                    if (rx_valid) begin
                        rf_addr <= rx_data[ADDR_WIDTH-1:0];
                        state   <= ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (rx_valid) begin
                        rf_wr_data <= rx_data;
                        rf_wr_en   <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (rx_valid) begin
                        rf_addr  <= rx_data[ADDR_WIDTH-1:0];
                        rf_rd_en <= 1'b1;
                        state    <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (rf_rd_valid) state <= ST_TX_SEND;
                end
                ST_OP_A: begin
                    if (rx_valid) begin
                        rf_addr    <= ADDR_WIDTH'(OPERAND_A_ADDR);
                        rf_wr_data <= rx_data;
                        rf_wr_en   <= 1'b1;
                        state      <= ST_OP_B;
                    end
                end
                ST_OP_B: begin
                    if (rx_valid) begin
                        rf_addr    <= ADDR_WIDTH'(OPERAND_B_ADDR);
                        rf_wr_data <= rx_data;
                        rf_wr_en   <= 1'b1;
                        state      <= ST_ALU_FUN;
                    end
                end
                ST_ALU_FUN: begin
                    if (rx_valid) begin
                        alu_fun <= rx_data[FUN_WIDTH-1:0];
                        alu_en  <= 1'b1;
                        gate_q  <= 1'b1;
                        state   <= ST_ALU_WAIT;
                    end
                end
                ST_ALU_WAIT: begin
                    if (alu_out_valid) begin
                        alu_en <= 1'b0;
                        gate_q <= 1'b0;
                        state  <= ST_TX_SEND;
                    end
                end
                ST_TX_SEND: begin
                    if (tx_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sys_ctrl_tx_seq #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tx_seq (
        .CLK       (CLK),
        .RST       (RST),
        .load      (tx_load),
        .load_data (tx_load_data),
        .load_two  (tx_load_two),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .done      (tx_done)
    );

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Self-checking bench for sys_cmd_ctrl: directed frames plus random frames,
// with register-file, ALU and UART-TX responders and a frame-level scoreboard.
module tb_sys_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [3:0]  rf_addr;
    logic        rf_wr_en;
    logic [7:0]  rf_wr_data;
    logic        rf_rd_en;
    logic [7:0]  rf_rd_data = 8'h00;
    logic        rf_rd_valid;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic [15:0] alu_out;
    logic        alu_out_valid;
    logic        clk_gate_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy = 1'b0;
    logic        cmd_err;

    logic        resp_rd_valid = 1'b0;
    logic        resp_alu_valid = 1'b0;
    logic [15:0] resp_alu_out = 16'h0;
    logic        spur_valid = 1'b0;
    logic        tx_active = 1'b0;
    logic        alu_override_en = 1'b0;
    logic [15:0] alu_override = 16'h0;

    assign rf_rd_valid   = resp_rd_valid | spur_valid;
    assign alu_out_valid = resp_alu_valid | spur_valid;
    assign alu_out       = spur_valid ? 16'hBEEF : resp_alu_out;

    always #5 CLK = ~CLK;

    sys_cmd_ctrl dut (
        .CLK           (CLK),
        .RST           (RST),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rf_addr       (rf_addr),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_data    (rf_wr_data),
        .rf_rd_en      (rf_rd_en),
        .rf_rd_data    (rf_rd_data),
        .rf_rd_valid   (rf_rd_valid),
        .alu_en        (alu_en),
        .alu_fun       (alu_fun),
        .alu_out       (alu_out),
        .alu_out_valid (alu_out_valid),
        .clk_gate_en   (clk_gate_en),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_busy       (tx_busy),
        .cmd_err       (cmd_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level expectations
    logic [11:0] exp_wr[$];
    logic [3:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [3:0]  exp_fun[$];
    int          exp_err = 0;
    logic [7:0]  model_rf[16];
    logic [7:0]  env_rf[16];

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return {8'h00, a} + {8'h00, b};
            4'd1:    return {8'h00, a} - {8'h00, b};
            4'd2:    return {8'h00, a} * {8'h00, b};
            4'd3:    return {8'h00, a & b};
            4'd4:    return {8'h00, a | b};
            4'd5:    return {8'h00, a ^ b};
            default: return {a, b};
        endcase
    endfunction

    // Compare process
    logic       prev_rx = 1'b0, prev_txv = 1'b0, prev_aen = 1'b0, prev_aov = 1'b0, prev_gate = 1'b0;
    logic [3:0] held_fun = 4'h0;
    always @(negedge CLK) begin
        logic [11:0] ew;
        logic [7:0]  et;
        logic [3:0]  ea;
        if (RST) begin
            prev_rx = 0; prev_txv = 0; prev_aen = 0; prev_aov = 0; prev_gate = 0;
        end else begin
            if (rf_wr_en) begin
                check("wr_cycle_after_byte", 32'(prev_rx), 32'(1));
                if (exp_wr.size() == 0) check("wr_unexpected", 32'(rf_wr_en), 32'(0));
                else begin
                    ew = exp_wr.pop_front();
                    check("wr_addr", 32'(rf_addr), 32'(ew[11:8]));
                    check("wr_data", 32'(rf_wr_data), 32'(ew[7:0]));
                end
            end
            if (rf_rd_en) begin
                check("rd_cycle_after_byte", 32'(prev_rx), 32'(1));
                if (exp_rd.size() == 0) check("rd_unexpected", 32'(rf_rd_en), 32'(0));
                else begin
                    ea = exp_rd.pop_front();
                    check("rd_addr", 32'(rf_addr), 32'(ea));
                end
            end
            if (cmd_err) begin
                if (exp_err == 0) check("err_unexpected", 32'(cmd_err), 32'(0));
                else begin
                    exp_err--;
                    check("err_alone", 32'({rf_wr_en, rf_rd_en, tx_valid, alu_en}), 32'(0));
                end
            end
            if (tx_valid) begin
                check("tx_while_busy", 32'(tx_busy), 32'(0));
                check("tx_back_to_back", 32'(prev_txv), 32'(0));
                if (exp_tx.size() == 0) check("tx_unexpected", 32'(tx_valid), 32'(0));
                else begin
                    et = exp_tx.pop_front();
                    check("tx_data", 32'(tx_data), 32'(et));
                end
            end
            if (alu_en && !prev_aen) begin
                check("gate_on_fun_cycle", 32'(prev_gate), 32'(1));
                if (exp_fun.size() == 0) check("alu_unexpected", 32'(alu_en), 32'(0));
                else begin
                    ea = exp_fun.pop_front();
                    check("alu_fun", 32'(alu_fun), 32'(ea));
                end
                held_fun = alu_fun;
            end
            if (alu_en) begin
                check("alu_fun_stable", 32'(alu_fun), 32'(held_fun));
                check("gate_with_alu_en", 32'(clk_gate_en), 32'(1));
            end
            if (prev_aov) check("alu_drop_after_result", 32'({alu_en, clk_gate_en}), 32'(0));
            prev_rx   = rx_valid;
            prev_txv  = tx_valid;
            prev_aen  = alu_en;
            prev_aov  = resp_alu_valid;
            prev_gate = clk_gate_en;
        end
    end

    // Register-file responder: writes land in env_rf; reads return after 2 cycles
    always @(negedge CLK) if (!RST && rf_wr_en) env_rf[rf_addr] = rf_wr_data;

    initial begin
        logic [3:0] a;
        forever begin
            @(negedge CLK);
            if (!RST && rf_rd_en) begin
                a = rf_addr;
                @(posedge CLK); #1;
                @(posedge CLK); #1;
                rf_rd_data = env_rf[a];
                resp_rd_valid = 1'b1;
                @(posedge CLK); #1;
                resp_rd_valid = 1'b0;
            end
        end
    end

    // ALU responder: computes from what the DUT actually wrote to addr 0/1
    initial begin
        logic [15:0] res;
        forever begin
            @(negedge CLK);
            if (!RST && alu_en) begin
                res = alu_override_en ? alu_override : alu_ref(env_rf[0], env_rf[1], alu_fun);
                repeat ($urandom_range(1, 4)) begin @(posedge CLK); #1; end
                resp_alu_out = res;
                resp_alu_valid = 1'b1;
                @(posedge CLK); #1;
                resp_alu_valid = 1'b0;
                for (int i = 0; i < 10 && alu_en; i++) @(negedge CLK);
            end
        end
    end

    // UART TX responder: busy rises 0-2 cycles after a pulse, stays 2-5 cycles
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && tx_valid) begin
                tx_active = 1'b1;
                @(posedge CLK); #1;
                repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
                tx_busy = 1'b1;
                repeat ($urandom_range(2, 5)) begin @(posedge CLK); #1; end
                tx_busy = 1'b0;
                tx_active = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) begin @(posedge CLK); #1; end
    endtask

    function automatic int rg();
        return int'($urandom_range(0, 2));
    endfunction

    task automatic wait_idle();
        int n = 0;
        while ((exp_wr.size() != 0 || exp_rd.size() != 0 || exp_tx.size() != 0 ||
                exp_fun.size() != 0 || exp_err != 0 || tx_busy || tx_active) && n < 400) begin
            @(posedge CLK); #1;
            n++;
        end
        if (n >= 400) check("idle_timeout", 32'(n), 32'(0));
        repeat (3) begin @(posedge CLK); #1; end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, 32'({rf_addr, rf_wr_en, rf_wr_data, rf_rd_en, alu_en, alu_fun,
                         clk_gate_en, tx_data, tx_valid, cmd_err}), 32'(0));
    endtask

    task automatic fr_wr(input logic [7:0] a, input logic [7:0] d);
        exp_wr.push_back({a[3:0], d});
        model_rf[a[3:0]] = d;
        send(8'hAA, rg()); send(a, rg()); send(d, 0);
    endtask

    task automatic fr_rd(input logic [7:0] a, input bit drop);
        exp_rd.push_back(a[3:0]);
        exp_tx.push_back(model_rf[a[3:0]]);
        send(8'hBB, rg()); send(a, 0);
        if (drop) send(8'hAA, 0);
    endtask

    task automatic fr_aluop(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f, input bit drop);
        logic [15:0] r;
        exp_wr.push_back({4'd0, a});
        exp_wr.push_back({4'd1, b});
        model_rf[0] = a;
        model_rf[1] = b;
        exp_fun.push_back(f[3:0]);
        r = alu_ref(a, b, f[3:0]);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
        send(8'hCC, rg()); send(a, rg()); send(b, rg()); send(f, 0);
        if (drop) send(8'hAA, 0);
    endtask

    task automatic fr_alunop(input logic [7:0] f);
        logic [15:0] r;
        exp_fun.push_back(f[3:0]);
        r = alu_ref(model_rf[0], model_rf[1], f[3:0]);
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
        send(8'hDD, rg()); send(f, 0);
    endtask

    initial begin
        logic [7:0] op;
        int kind;
        for (int i = 0; i < 16; i++) begin model_rf[i] = 8'h00; env_rf[i] = 8'h00; end
        RST = 1'b1;
        rx_data = 8'h5A;
        rx_valid = 1'b1;
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset_outputs");
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        RST = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end

        // 1: write 3C to addr 5
        exp_wr.push_back(12'h53C);
        model_rf[5] = 8'h3C;
        send(8'hAA, 1); send(8'h05, 0); send(8'h3C, 0);
        wait_idle();

        // 2: read addr 5 -> one byte 3C
        exp_rd.push_back(4'h5);
        exp_tx.push_back(8'h3C);
        send(8'hBB, 0); send(8'h05, 0);
        wait_idle();

        // 3: ALU_OP 12 + 34 -> 0x0046
        exp_wr.push_back(12'h012);
        exp_wr.push_back(12'h134);
        model_rf[0] = 8'h12;
        model_rf[1] = 8'h34;
        exp_fun.push_back(4'h0);
        exp_tx.push_back(8'h46);
        exp_tx.push_back(8'h00);
        send(8'hCC, 0); send(8'h12, 1); send(8'h34, 0); send(8'h00, 0);
        wait_idle();

        // 4: ALU_NOP with a forced ALU result
        alu_override_en = 1'b1;
        alu_override = 16'hABCD;
        exp_fun.push_back(4'h2);
        exp_tx.push_back(8'hCD);
        exp_tx.push_back(8'hAB);
        send(8'hDD, 0); send(8'h02, 0);
        wait_idle();
        alu_override_en = 1'b0;

        // 5: unknown opcode, then a byte dropped during TX_SEND, then a write
        exp_err++;
        send(8'h55, 0);
        wait_idle();
        exp_rd.push_back(4'h5);
        exp_tx.push_back(8'h3C);
        send(8'hBB, 0); send(8'hF5, 0);
        for (int i = 0; i < 50 && !tx_valid; i++) @(negedge CLK);
        if (!tx_valid) check("tx_start_timeout", 32'(tx_valid), 32'(1));
        @(posedge CLK); #1;
        send(8'h55, 0);
        wait_idle();
        exp_wr.push_back(12'h799);
        model_rf[7] = 8'h99;
        send(8'hAA, 0); send(8'h07, 0); send(8'h99, 0);
        wait_idle();

        // Stray rd/alu valid pulses while idle are ignored
        spur_valid = 1'b1;
        @(posedge CLK); #1;
        spur_valid = 1'b0;
        wait_idle();

        // 6: reset mid-frame aborts, next frame writes correctly
        send(8'hAA, 0); send(8'h05, 0);
        RST = 1'b1;
        @(negedge CLK);
        check_reset_outputs("reset_midframe_outputs");
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        exp_wr.push_back(12'h53C);
        model_rf[5] = 8'h3C;
        send(8'hAA, 0); send(8'h05, 0); send(8'h3C, 0);
        wait_idle();

        // Random frames
        for (int it = 0; it < 60; it++) begin
            kind = int'($urandom_range(0, 4));
            case (kind)
                0: fr_wr(8'($urandom), 8'($urandom));
                1: fr_rd(8'($urandom), ($urandom_range(0, 3) == 0));
                2: fr_aluop(8'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
                3: fr_alunop(8'($urandom));
                default: begin
                    do op = 8'($urandom); while (op == 8'hAA || op == 8'hBB || op == 8'hCC || op == 8'hDD);
                    exp_err++;
                    send(op, 0);
                end
            endcase
            wait_idle();
        end

        check("left_wr", 32'(exp_wr.size()), 32'(0));
        check("left_rd", 32'(exp_rd.size()), 32'(0));
        check("left_tx", 32'(exp_tx.size()), 32'(0));
        check("left_fun", 32'(exp_fun.size()), 32'(0));
        check("left_err", 32'(exp_err), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
